// File: rtl/spike_count_classifier.sv
// Spike-count classifier: counts per-neuron spikes over a window, then scans for the most active neuron; SPIKE_COUNT_READBACK_EN adds a counter readback port.
// Latency: 1+window_len+NUM_NEURONS cycles from start to result_valid; the result is held until result_ready is seen in DONE.
module spike_count_classifier #(
  parameter int NUM_NEURONS  = 10,
  parameter int COUNT_WIDTH  = 8,
  parameter int WINDOW_WIDTH = 16,
  localparam int IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_NEURONS-1:0]  spike_in,
  input  logic                    start,
  input  logic [WINDOW_WIDTH-1:0] window_len,
  output logic                    busy,
  output logic                    result_valid,
  input  logic                    result_ready,
  output logic [IDX_W-1:0]        result_idx,
  output logic [COUNT_WIDTH-1:0]  result_count
`ifdef SPIKE_COUNT_READBACK_EN
  ,
  input  logic [IDX_W-1:0]        rd_sel,
  output logic [COUNT_WIDTH-1:0]  rd_count
`endif
);

  typedef enum logic [1:0] {IDLE, COUNT, SCAN, DONE} state_e;

  localparam logic [COUNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [IDX_W-1:0]       LAST_IDX = IDX_W'(NUM_NEURONS - 1);

  state_e                  state_q, state_d;
  logic [COUNT_WIDTH-1:0]  cnt_q [NUM_NEURONS];
  logic [COUNT_WIDTH-1:0]  cnt_d [NUM_NEURONS];
  logic [WINDOW_WIDTH-1:0] len_q, len_d;
  logic [WINDOW_WIDTH-1:0] step_q, step_d;
  logic [IDX_W-1:0]        scan_idx_q, scan_idx_d;
  logic [IDX_W-1:0]        best_idx_q, best_idx_d;
  logic [COUNT_WIDTH-1:0]  best_cnt_q, best_cnt_d;
  logic [IDX_W-1:0]        res_idx_q, res_idx_d;
  logic [COUNT_WIDTH-1:0]  res_cnt_q, res_cnt_d;

  logic                    take;
  logic [IDX_W-1:0]        cand_idx;
  logic [COUNT_WIDTH-1:0]  cand_cnt;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    step_d     = step_q;
    scan_idx_d = scan_idx_q;
    best_idx_d = best_idx_q;
    best_cnt_d = best_cnt_q;
    res_idx_d  = res_idx_q;
    res_cnt_d  = res_cnt_q;
    // Strictly-greater replacement keeps the lowest index on ties.
    take     = cnt_q[scan_idx_q] > best_cnt_q;
    cand_idx = take ? scan_idx_q : best_idx_q;
    cand_cnt = take ? cnt_q[scan_idx_q] : best_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          for (int i = 0; i < NUM_NEURONS; i++) begin
            cnt_d[i] = '0;
          end
          len_d      = window_len;
          step_d     = '0;
          scan_idx_d = '0;
          best_idx_d = '0;
          best_cnt_d = '0;
          state_d    = (window_len == '0) ? SCAN : COUNT;
        end
      end
      COUNT: begin
        for (int i = 0; i < NUM_NEURONS; i++) begin
          if (spike_in[i] && (cnt_q[i] != CNT_MAX)) begin
            cnt_d[i] = cnt_q[i] + COUNT_WIDTH'(1);
          end
        end
        if (step_q == len_q - WINDOW_WIDTH'(1)) begin
          state_d = SCAN;
        end else begin
          step_d = step_q + WINDOW_WIDTH'(1);
        end
      end
      SCAN: begin
        best_idx_d = cand_idx;
        best_cnt_d = cand_cnt;
        if (scan_idx_q == LAST_IDX) begin
          res_idx_d = cand_idx;
          res_cnt_d = cand_cnt;
          state_d   = DONE;
        end else begin
          scan_idx_d = scan_idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (result_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      len_q      <= '0;
      step_q     <= '0;
      scan_idx_q <= '0;
      best_idx_q <= '0;
      best_cnt_q <= '0;
      res_idx_q  <= '0;
      res_cnt_q  <= '0;
      for (int i = 0; i < NUM_NEURONS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      step_q     <= step_d;
      scan_idx_q <= scan_idx_d;
      best_idx_q <= best_idx_d;
      best_cnt_q <= best_cnt_d;
      res_idx_q  <= res_idx_d;
      res_cnt_q  <= res_cnt_d;
      cnt_q      <= cnt_d;
    end
  end

  // Outputs read as zero for the whole time rst is high, not only after the edge.
  assign busy         = !rst && (state_q != IDLE);
  assign result_valid = !rst && (state_q == DONE);
  assign result_idx   = rst ? '0 : res_idx_q;
  assign result_count = rst ? '0 : res_cnt_q;

`ifdef SPIKE_COUNT_READBACK_EN
  localparam logic [IDX_W:0] NUM_EXT = (IDX_W + 1)'(NUM_NEURONS);
  assign rd_count = ({1'b0, rd_sel} < NUM_EXT) ? cnt_q[rd_sel] : '0;
`endif

  a_result_hold: assert property (@(posedge clk) disable iff (rst)
    (result_valid && !result_ready) |=> (result_valid && $stable(result_idx) && $stable(result_count)));

endmodule

// File: tb/tb_spike_count_classifier.sv
// Bench for spike_count_classifier: two instances (8-bit and 4-bit counters) share one stimulus stream.
module tb_spike_count_classifier;

  localparam int NN = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  spike_in;
  logic        start;
  logic [15:0] window_len;
  logic        result_ready;

  logic        busy8, valid8, busy4, valid4;
  logic [3:0]  idx8, idx4;
  logic [7:0]  cnt8;
  logic [3:0]  cnt4;

`ifdef SPIKE_COUNT_READBACK_EN
  logic [3:0]  rd_sel = 4'd0;
  logic [7:0]  rd_count8;
  logic [3:0]  rd_count4;
`endif

  int nchk = 0;
  int nerr = 0;

  spike_count_classifier #(.NUM_NEURONS(NN), .COUNT_WIDTH(8), .WINDOW_WIDTH(16)) dut8 (
    .clk(clk), .rst(rst), .spike_in(spike_in), .start(start), .window_len(window_len),
    .busy(busy8), .result_valid(valid8), .result_ready(result_ready),
    .result_idx(idx8), .result_count(cnt8)
`ifdef SPIKE_COUNT_READBACK_EN
    , .rd_sel(rd_sel), .rd_count(rd_count8)
`endif
  );

  spike_count_classifier #(.NUM_NEURONS(NN), .COUNT_WIDTH(4), .WINDOW_WIDTH(16)) dut4 (
    .clk(clk), .rst(rst), .spike_in(spike_in), .start(start), .window_len(window_len),
    .busy(busy4), .result_valid(valid4), .result_ready(result_ready),
    .result_idx(idx4), .result_count(cnt4)
`ifdef SPIKE_COUNT_READBACK_EN
    , .rd_sel(rd_sel), .rd_count(rd_count4)
`endif
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: a window is a time span after the accepting edge.
  int  k = 0;
  int  m_t0, m_len;
  bit  m_active = 0, m_done = 0;
  int  raw [NN];
  int  e_idx8 = 0, e_cnt8 = 0, e_idx4 = 0, e_cnt4 = 0;

  task automatic pick(input int w, output int bi, output int bc);
    int sat, c;
    sat = (1 << w) - 1;
    bi = 0;
    bc = 0;
    for (int i = 0; i < NN; i++) begin
      c = (raw[i] > sat) ? sat : raw[i];
      if (c > bc) begin
        bc = c;
        bi = i;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    k++;
    if (rst) begin
      m_active = 0; m_done = 0;
      e_idx8 = 0; e_cnt8 = 0; e_idx4 = 0; e_cnt4 = 0;
    end else if (!m_active) begin
      if (start) begin
        m_active = 1;
        m_t0 = k;
        m_len = int'(window_len);
        for (int i = 0; i < NN; i++) raw[i] = 0;
      end
    end else if (!m_done) begin
      if (k - m_t0 <= m_len)
        for (int i = 0; i < NN; i++) raw[i] += int'(spike_in[i]);
      if (k - m_t0 == m_len + NN) begin
        m_done = 1;
        pick(8, e_idx8, e_cnt8);
        pick(4, e_idx4, e_cnt4);
      end
    end else if (result_ready) begin
      m_active = 0; m_done = 0;
    end
  end

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("busy8",  int'(busy8),  rst ? 0 : int'(m_active));
      chk("valid8", int'(valid8), rst ? 0 : int'(m_done));
      chk("idx8",   int'(idx8),   rst ? 0 : e_idx8);
      chk("cnt8",   int'(cnt8),   rst ? 0 : e_cnt8);
      chk("busy4",  int'(busy4),  rst ? 0 : int'(m_active));
      chk("valid4", int'(valid4), rst ? 0 : int'(m_done));
      chk("idx4",   int'(idx4),   rst ? 0 : e_idx4);
      chk("cnt4",   int'(cnt4),   rst ? 0 : e_cnt4);
    end
  end

  // Spike pattern p at COUNT cycle t (t = 1 is the first counted timestep).
  function automatic logic [9:0] pat(input int p, input int t);
    logic [9:0] s;
    s = '0;
    case (p)
      1: begin s[3] = 1'b1; if (t % 2 == 0) s[7] = 1'b1; end
      2: begin if (t % 2 == 1) s[2] = 1'b1; else s[5] = 1'b1; end
      3: s[9] = 1'b1;
      5: s[6] = 1'b1;
      6: s[8] = 1'b1;
      7: s[1] = 1'b1;
      default: s = '0;
    endcase
    return s;
  endfunction

  // Called just after a rising edge with the DUT idle; returns once result_valid is seen.
  task automatic do_run(input int wl, input int p, input int x_idx, input int x_cnt8,
                        input int x_cnt4, input int x_lat);
    int lat;
    start = 1'b1;
    window_len = 16'(wl);
    spike_in = '0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
      spike_in = (lat <= wl) ? pat(p, lat) : 10'd0;
    end while (!valid8 && lat < 200);
    chk("latency", lat, x_lat);
    chk("lit_valid4", int'(valid4), 1);
    chk("lit_idx8", int'(idx8), x_idx);
    chk("lit_cnt8", int'(cnt8), x_cnt8);
    chk("lit_idx4", int'(idx4), x_idx);
    chk("lit_cnt4", int'(cnt4), x_cnt4);
  endtask

  task automatic finish_hs();
    @(posedge clk); #1;
    chk("idle_busy", int'(busy8), 0);
    chk("idle_valid", int'(valid8), 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; result_ready = 1'b1; spike_in = '0; window_len = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy8), 0);
    chk("rst_valid", int'(valid8), 0);
    chk("rst_idx", int'(idx8), 0);
    chk("rst_cnt", int'(cnt8), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_run(20, 1, 3, 20, 15, 31); finish_hs();
    do_run(12, 2, 2, 6, 6, 23);   finish_hs();
    do_run(40, 3, 9, 40, 15, 51); finish_hs();
    do_run(0, 0, 0, 0, 0, 11);    finish_hs();
    do_run(5, 0, 0, 0, 0, 16);    finish_hs();

    // Hold result_ready low in DONE; a start pulse there must be ignored.
    result_ready = 1'b0;
    do_run(3, 5, 6, 3, 3, 14);
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      start = (i == 4);
      window_len = 16'd7;
      chk("hold_valid", int'(valid8), 1);
      chk("hold_idx", int'(idx8), 6);
      chk("hold_cnt", int'(cnt8), 3);
    end
    start = 1'b0;
    result_ready = 1'b1;
    finish_hs();
    chk("retain_idx", int'(idx8), 6);
    chk("retain_cnt", int'(cnt8), 3);
    @(posedge clk); #1;
    chk("no_restart", int'(busy8), 0);

    // Reset in the fifth COUNT cycle.
    start = 1'b1;
    window_len = 16'd10;
    for (int lat = 1; lat <= 5; lat++) begin
      @(posedge clk); #1;
      start = 1'b0;
      spike_in = pat(6, lat);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    spike_in = '0;
    chk("midrst_busy", int'(busy8), 0);
    chk("midrst_valid", int'(valid8), 0);
    chk("midrst_idx", int'(idx8), 0);
    chk("midrst_cnt", int'(cnt8), 0);
    @(posedge clk); #1;
    do_run(4, 7, 1, 4, 4, 15); finish_hs();

    repeat (2) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
